vram_scroll_arbiter: RTL and testbench

Sits between the text editor's video-RAM port and the single-port 2K x 16 video RAM. When idle, it passes the editor's accesses straight through to the RAM. On request, it takes exclusive ownership of the RAM and runs one of two bulk jobs:
- Full-screen clear: fill every cell with a supplied word.
- One-line scroll-up: copy each row to the row above, then clear the bottom row.
This gives the terminal scrolling without the editor having to sequence 1000+ RAM cycles itself.

---
 rtl/vram_scroll_arbiter_if.sv | 14 +
 rtl/vram_scroll_arbiter.sv | 129 ++++++++++++
 tb/tb_vram_scroll_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_scroll_arbiter_if.sv
// Single-port video-RAM bus: address, write data, write enable, and read data
// that is valid one cycle after a read address is presented.
interface vram_scroll_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 16
);
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          we;
  logic [DW-1:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/vram_scroll_arbiter.sv
// Passes editor accesses through to the video RAM when idle; otherwise owns the
// RAM and runs a full-screen clear or a one-row scroll-up.
module vram_scroll_arbiter #(
  parameter int COLS = 40,
  parameter int ROWS = 28,
  parameter int AW   = 11,
  parameter int DW   = 16
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  vram_scroll_arbiter_if.slave  client,
  vram_scroll_arbiter_if.master ram,
  input  logic                  scroll_req,
  input  logic                  clear_req,
  input  logic [DW-1:0]         fill_word,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  // Job handshake: clear_req/scroll_req are single-cycle pulses honoured only in
  // IDLE (clear wins a tie); busy covers every RAM-owning cycle and done pulses
  // once in the cycle after the final write. Requests seen otherwise are dropped.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    SC_RD   = 3'd2,
    SC_WR   = 3'd3,
    SC_LAST = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [AW-1:0] CELL_LAST   = AW'(COLS*ROWS - 1);
  localparam logic [AW-1:0] COPY_LAST   = AW'(COLS*(ROWS-1) - 1);
  localparam logic [AW-1:0] BOTTOM_ROW  = AW'(COLS*(ROWS-1));
  localparam logic [AW-1:0] ROW_STRIDE  = AW'(COLS);
  localparam logic [DW-1:0] CURSOR_MASK = ~(DW'(1) << 14);

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    ram.addr  = client.addr;
    ram.wdata = client.wdata;
    ram.we    = client.we;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nx = CLR;
          idx_nx   = '0;
        end else if (scroll_req) begin
          state_nx = SC_RD;
          idx_nx   = '0;
        end
      end

      CLR, SC_LAST: begin
        busy      = 1'b1;
        ram.addr  = idx;
        ram.wdata = fill_word;
        ram.we    = 1'b1;
        if (idx == CELL_LAST) begin
          state_nx = FIN;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end

      SC_RD: begin
        busy      = 1'b1;
        ram.addr  = idx + ROW_STRIDE;
        ram.wdata = fill_word;
        ram.we    = 1'b0;
        state_nx  = SC_WR;
      end

      SC_WR: begin
        // The cursor stays only where the editor puts it, never on the copy.
        busy      = 1'b1;
        ram.addr  = idx;
        ram.wdata = ram.rdata & CURSOR_MASK;
        ram.we    = 1'b1;
        if (idx == COPY_LAST) begin
          idx_nx   = BOTTOM_ROW;
          state_nx = SC_LAST;
        end else begin
          idx_nx   = idx + 1'b1;
          state_nx = SC_RD;
        end
      end

      FIN: begin
        done      = 1'b1;
        ram.addr  = idx;
        ram.wdata = fill_word;
        ram.we    = 1'b0;
        state_nx  = IDLE;
      end

      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase

    if (reset) begin
      ram.we = 1'b0;
    end
  end

  assign client.rdata = ram.rdata;
  assign state_dbg    = state;

endmodule

// File: tb/tb_vram_scroll_arbiter.sv
// Directed bench for vram_scroll_arbiter: pass-through vector table, then
// clear, scroll, tie-break, reset-abort and FIN-request sequences on a RAM model.
module tb_vram_scroll_arbiter;

  localparam int COLS  = 40;
  localparam int ROWS  = 28;
  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int CELLS = COLS*ROWS;

  logic          sys_clk;
  logic          reset;
  logic          scroll_req;
  logic          clear_req;
  logic [DW-1:0] fill_word;
  logic          busy;
  logic          done;
  logic [2:0]    state_dbg;

  vram_scroll_arbiter_if #(.AW(AW), .DW(DW)) client_bus ();
  vram_scroll_arbiter_if #(.AW(AW), .DW(DW)) ram_bus ();

  vram_scroll_arbiter #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .DW(DW)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .client     (client_bus),
    .ram        (ram_bus),
    .scroll_req (scroll_req),
    .clear_req  (clear_req),
    .fill_word  (fill_word),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // 2K x 16 RAM model, registered read
  logic [DW-1:0] mem [0:2047];
  always @(posedge sys_clk) begin
    ram_bus.rdata <= mem[ram_bus.addr];
    if (ram_bus.we) mem[ram_bus.addr] = ram_bus.wdata;
  end

  // scoreboard state
  int checks;
  int errors;
  int done_cnt;
  int range_viol;

  always @(negedge sys_clk) begin
    if (done) done_cnt++;
    if (ram_bus.we && busy && (int'(ram_bus.addr) >= CELLS)) range_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic pulse(input logic c, input logic s);
    clear_req  = c;
    scroll_req = s;
    step();
    clear_req  = 1'b0;
    scroll_req = 1'b0;
  endtask

  task automatic run_job(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      n++;
      step();
    end
  endtask

  function automatic int count_bad(input int lo, input int hi, input logic [DW-1:0] val);
    int bad;
    bad = 0;
    for (int a = lo; a <= hi; a++) if (mem[a] !== val) bad++;
    return bad;
  endfunction

  task automatic preload_rows();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mem[r*COLS + c] = 16'h0F00 | 16'(r);
    mem[45] = 16'h4F2A;
  endtask

  typedef struct {
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_we;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int d0;
    int busy_seen;
    int bad;

    checks = 0; errors = 0; done_cnt = 0; range_viol = 0;
    for (int a = 0; a < 2048; a++) mem[a] = '0;

    vecs[0] = '{1'b0, 11'd5,    16'h0F41, 1'b1, 11'd5,    16'h0F41, 1'b1};
    vecs[1] = '{1'b0, 11'd1119, 16'h1234, 1'b0, 11'd1119, 16'h1234, 1'b0};
    vecs[2] = '{1'b0, 11'd0,    16'hFFFF, 1'b1, 11'd0,    16'hFFFF, 1'b1};
    vecs[3] = '{1'b1, 11'd7,    16'hABCD, 1'b1, 11'd7,    16'hABCD, 1'b0};
    vecs[4] = '{1'b0, 11'd1000, 16'h0055, 1'b1, 11'd1000, 16'h0055, 1'b1};

    reset = 1'b1; scroll_req = 1'b0; clear_req = 1'b0; fill_word = '0;
    client_bus.addr = '0; client_bus.wdata = '0; client_bus.we = 1'b0;
    repeat (3) step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    step();

    // pass-through / reset-gating vector table
    for (int i = 0; i < 5; i++) begin
      reset = vecs[i].rst;
      client_bus.addr  = vecs[i].addr;
      client_bus.wdata = vecs[i].wdata;
      client_bus.we    = vecs[i].we;
      #1;
      chk($sformatf("vec%0d_addr", i),  32'(ram_bus.addr),  32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_wdata", i), 32'(ram_bus.wdata), 32'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d_we", i),    32'(ram_bus.we),    32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_busy", i),  32'(busy),          32'd0);
      chk($sformatf("vec%0d_done", i),  32'(done),          32'd0);
      step();
    end
    reset = 1'b0;

    // read mirror of what vector 0 wrote
    client_bus.addr = 11'd5; client_bus.we = 1'b0;
    step();
    chk("rdata_mirror", 32'(client_bus.rdata), 32'h0F41);

    // full clear with client trying to write underneath
    fill_word = 16'h0F00;
    client_bus.addr = 11'd3; client_bus.wdata = 16'hDEAD; client_bus.we = 1'b1;
    d0 = done_cnt;
    pulse(1'b1, 1'b0);
    chk("clr_busy_start", 32'(busy), 32'd1);
    chk("clr_we_busy", 32'(ram_bus.we), 32'd1);
    run_job(5000, n);
    chk("clr_cycles", 32'(n), 32'd1120);
    chk("clr_fin_done", 32'(done), 32'd1);
    chk("clr_fin_busy", 32'(busy), 32'd0);
    chk("clr_fin_we", 32'(ram_bus.we), 32'd0);
    client_bus.we = 1'b0;
    step();
    chk("clr_done_drop", 32'(done), 32'd0);
    chk("clr_idle", 32'(state_dbg), 32'd0);
    chk("clr_bad_cells", 32'(count_bad(0, CELLS-1, 16'h0F00)), 32'd0);
    chk("clr_client_blocked", 32'(mem[3]), 32'h0F00);
    chk("clr_done_cnt", 32'(done_cnt - d0), 32'd1);

    // simultaneous requests and a mid-job scroll pulse
    fill_word = 16'h1234;
    d0 = done_cnt;
    pulse(1'b1, 1'b1);
    chk("tie_state_clr", 32'(state_dbg), 32'd1);
    n = 0;
    while (busy && n < 5000) begin
      scroll_req = (n == 300);
      n++;
      step();
    end
    scroll_req = 1'b0;
    chk("tie_cycles", 32'(n), 32'd1120);
    repeat (4) step();
    chk("tie_busy_after", 32'(busy), 32'd0);
    chk("tie_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("tie_bad_cells", 32'(count_bad(0, CELLS-1, 16'h1234)), 32'd0);

    // scroll-up, then requests pulsed during FIN
    preload_rows();
    fill_word = 16'h0F20;
    d0 = done_cnt;
    pulse(1'b0, 1'b1);
    chk("scr_state_rd", 32'(state_dbg), 32'd2);
    run_job(5000, n);
    chk("scr_cycles", 32'(n), 32'd2200);
    chk("scr_fin_done", 32'(done), 32'd1);
    clear_req = 1'b1; scroll_req = 1'b1;
    step();
    clear_req = 1'b0; scroll_req = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy) busy_seen++;
      step();
    end
    chk("fin_req_dropped", 32'(busy_seen), 32'd0);
    chk("scr_done_cnt", 32'(done_cnt - d0), 32'd1);
    bad = 0;
    for (int r = 0; r < ROWS-1; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == 0 && c == 5) && mem[r*COLS + c] !== (16'h0F00 | 16'(r+1))) bad++;
    chk("scr_bad_rows", 32'(bad), 32'd0);
    chk("scr_cursor_cleared", 32'(mem[5]), 32'h0F2A);
    chk("scr_addr45", 32'(mem[45]), 32'h0F02);
    chk("scr_row0_col0", 32'(mem[0]), 32'h0F01);
    chk("scr_row26", 32'(mem[1079]), 32'h0F1B);
    chk("scr_bottom_bad", 32'(count_bad(CELLS-COLS, CELLS-1, 16'h0F20)), 32'd0);

    // reset in the middle of a scroll
    preload_rows();
    d0 = done_cnt;
    pulse(1'b0, 1'b1);
    run_job(500, n);
    chk("abort_still_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    client_bus.addr = 11'd9; client_bus.wdata = 16'h1111; client_bus.we = 1'b1;
    #1;
    chk("abort_we_forced", 32'(ram_bus.we), 32'd0);
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_we", 32'(ram_bus.we), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_pass_we", 32'(ram_bus.we), 32'd1);
    chk("abort_pass_addr", 32'(ram_bus.addr), 32'd9);
    step();
    client_bus.we = 1'b0;
    chk("abort_pass_write", 32'(mem[9]), 32'h1111);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    fill_word = 16'h0A0A;
    pulse(1'b1, 1'b0);
    run_job(5000, n);
    chk("post_clr_cycles", 32'(n), 32'd1120);
    chk("post_clr_done", 32'(done), 32'd1);
    step();
    chk("post_clr_bad_cells", 32'(count_bad(0, CELLS-1, 16'h0A0A)), 32'd0);
    chk("post_clr_done_cnt", 32'(done_cnt - d0), 32'd1);

    chk("addr_range", 32'(range_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
